// File: rtl/signal_trace_buffer_if.sv
// Probe, control and read-back bundle for signal_trace_buffer.
// Trigger pattern signals exist only when TRACE_TRIGGER_EN is defined.
interface signal_trace_buffer_if #(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]          probe;
    logic                         arm;
    logic                         stop;
    logic                         mode;
`ifdef TRACE_TRIGGER_EN
    logic [CHANNELS-1:0]          trig_mask;
    logic [CHANNELS-1:0]          trig_value;
`endif
    logic                         rd_en;
    logic [TS_WIDTH+CHANNELS-1:0] rd_data;
    logic                         rd_valid;
    logic [CW-1:0]                count;
    logic [1:0]                   state;
    logic                         overflow;

`ifdef TRACE_TRIGGER_EN
    modport master (output probe, arm, stop, mode, trig_mask, trig_value, rd_en,
                    input  rd_data, rd_valid, count, state, overflow);
    modport slave  (input  probe, arm, stop, mode, trig_mask, trig_value, rd_en,
                    output rd_data, rd_valid, count, state, overflow);
`else
    modport master (output probe, arm, stop, mode, rd_en,
                    input  rd_data, rd_valid, count, state, overflow);
    modport slave  (input  probe, arm, stop, mode, rd_en,
                    output rd_data, rd_valid, count, state, overflow);
`endif
endinterface

// File: rtl/signal_trace_buffer.sv
// Change-driven logic recorder: stores {delta, probe} whenever the probe vector changes.
// Optional pattern trigger (WAIT_TRIG state, trig_mask/trig_value) enabled by TRACE_TRIGGER_EN.
//
// state     | meaning
// IDLE      | after reset, nothing captured
// WAIT_TRIG | armed, waiting for masked probe match
// CAPTURE   | recording probe changes
// STOPPED   | capture ended, entries readable
module signal_trace_buffer #(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    signal_trace_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TS_WIDTH + CHANNELS;
    localparam logic [CW-1:0]       FULL   = CW'(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        STOPPED   = 2'd3
    } state_t;

`ifdef TRACE_TRIGGER_EN
    localparam state_t ARM_STATE = WAIT_TRIG;
    logic trig_hit;
    assign trig_hit = (bus.probe & bus.trig_mask) == (bus.trig_value & bus.trig_mask);
`else
    localparam state_t ARM_STATE = CAPTURE;
`endif

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic                first_q, first_d;
    logic                mode_q, mode_d;
    logic                ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic                wr_en;
    logic [EW-1:0]       wr_data;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ts_d     = ts_q;
        prev_d   = prev_q;
        first_d  = first_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_data  = '0;
        if (bus.arm) begin
            state_d  = ARM_STATE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            mode_d   = bus.mode;
            first_d  = 1'b1;
            ts_d     = '0;
        end else begin
            case (state_q)
`ifdef TRACE_TRIGGER_EN
                WAIT_TRIG: begin
                    prev_d  = bus.probe;
                    first_d = 1'b0;
                    if (bus.stop) begin
                        state_d = STOPPED;
                    end else if (trig_hit) begin
                        wr_en   = 1'b1;
                        wr_data = {TS_WIDTH'(0), bus.probe};
                        state_d = CAPTURE;
                    end
                end
`endif
                CAPTURE: begin
                    prev_d  = bus.probe;
                    first_d = 1'b0;
                    if (first_q) begin
                        wr_en   = 1'b1;
                        wr_data = {TS_WIDTH'(0), bus.probe};
                    end else if (bus.probe != prev_q) begin
                        wr_en   = 1'b1;
                        wr_data = {ts_q, bus.probe};
                    end
                    if (bus.stop) state_d = STOPPED;
                end
                STOPPED: begin
                    if (bus.rd_en && count_q != '0) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
                default: ;
            endcase

            // ts_q holds edges elapsed since the last write, as seen by the next edge
            if (state_q == WAIT_TRIG || state_q == CAPTURE)
                ts_d = wr_en ? TS_WIDTH'(1) : ((ts_q == TS_MAX) ? ts_q : ts_q + TS_WIDTH'(1));

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (count_q == FULL) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    ovf_d    = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                    if (mode_q && count_q == FULL - CW'(1)) state_d = STOPPED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            prev_q   <= '0;
            first_q  <= 1'b0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.rd_valid = (state_q == STOPPED) && (count_q != '0);
    assign bus.rd_data  = bus.rd_valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_signal_trace_buffer.sv
// Self-checking bench for signal_trace_buffer (CHANNELS=8, DEPTH=4, TS_WIDTH=4).
module tb_signal_trace_buffer;
    localparam int CH = 8;
    localparam int DP = 4;
    localparam int TW = 4;
    localparam int EW = CH + TW;
    localparam int TSMAX = (1 << TW) - 1;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    signal_trace_buffer_if #(.CHANNELS(CH), .DEPTH(DP), .TS_WIDTH(TW)) bus ();
    signal_trace_buffer #(.CHANNELS(CH), .DEPTH(DP), .TS_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.probe = '0;
        bus.arm   = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.rd_en = 1'b0;
`ifdef TRACE_TRIGGER_EN
        bus.trig_mask  = '0;
        bus.trig_value = '0;
`endif
    endtask

    task automatic do_arm(input logic m);
        bus.arm  = 1'b1;
        bus.mode = m;
        step();
        bus.arm  = 1'b0;
    endtask

    task automatic sample(input logic [CH-1:0] p, input logic s);
        bus.probe = p;
        bus.stop  = s;
        step();
        bus.stop  = 1'b0;
    endtask

    // Drains everything with back-to-back pops, comparing against exp_q.
    task automatic check_drain(input string name, input logic exp_ovf);
        logic [EW-1:0] e;
        n_tests++;
        if (bus.state !== 2'd3) begin
            n_fail++; $display("FAIL %s state: got %0d expected 3", name, bus.state);
        end
        n_tests++;
        if (bus.count !== 3'(exp_q.size())) begin
            n_fail++; $display("FAIL %s count: got %0d expected %0d", name, bus.count, exp_q.size());
        end
        n_tests++;
        if (bus.overflow !== exp_ovf) begin
            n_fail++; $display("FAIL %s overflow: got %b expected %b", name, bus.overflow, exp_ovf);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                n_fail++;
                $display("FAIL %s read: got valid=%b data=%h expected valid=1 data=%h",
                         name, bus.rd_valid, bus.rd_data, e);
            end
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        n_tests++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.count !== '0) begin
            n_fail++;
            $display("FAIL %s empty: got valid=%b data=%h count=%0d expected 0/0/0",
                     name, bus.rd_valid, bus.rd_data, bus.count);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0 || bus.rd_valid !== 1'b0 ||
            bus.rd_data !== '0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got state=%0d count=%0d valid=%b data=%h ovf=%b expected all 0",
                     name, bus.state, bus.count, bus.rd_valid, bus.rd_data, bus.overflow);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset_initial");
        #3 rst_n = 1'b1;
        step();
        do_arm(1'b0);
        sample(8'h11, 1'b0);
        sample(8'h22, 1'b0);
        sample(8'h33, 1'b0);
        n_tests++;
        if (bus.count !== 3'd3 || bus.state !== 2'd2) begin
            n_fail++; $display("FAIL reset_precapture: got count=%0d state=%0d expected 3/2", bus.count, bus.state);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_capture");
        #3 rst_n = 1'b1;
        step();
        do_arm(1'b0);
        sample(8'h44, 1'b0);
        sample(8'h55, 1'b0);
        sample(8'h66, 1'b1);
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== {4'd0, 8'h44}) begin
            n_fail++; $display("FAIL reset_prereadout: got valid=%b data=%h expected 1/044", bus.rd_valid, bus.rd_data);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_readout");
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_stop_on_full();
        do_arm(1'b1);
        sample(8'h00, 1'b0);
        sample(8'h00, 1'b0);
        sample(8'h00, 1'b0);
        sample(8'h01, 1'b0);
        sample(8'h01, 1'b0);
        sample(8'h03, 1'b0);
        sample(8'h07, 1'b0);
        n_tests++;
        if (bus.state !== 2'd3) begin
            n_fail++; $display("FAIL full_stop_edge: got state=%0d expected 3", bus.state);
        end
        sample(8'hFF, 1'b0);
        exp_q = '{{4'd0, 8'h00}, {4'd3, 8'h01}, {4'd2, 8'h03}, {4'd1, 8'h07}};
        check_drain("stop_on_full", 1'b0);
    endtask

    task automatic test_wrap();
        do_arm(1'b0);
        sample(8'h00, 1'b0);
        sample(8'h00, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            sample(8'(k), 1'b0);
            sample(8'(k), k == 6);
        end
        exp_q = '{{4'd2, 8'h03}, {4'd2, 8'h04}, {4'd2, 8'h05}, {4'd2, 8'h06}};
        check_drain("wrap", 1'b1);
    endtask

    task automatic test_saturation();
        do_arm(1'b0);
        for (int i = 0; i < 41; i++) sample(8'h5A, 1'b0);
        sample(8'hA5, 1'b1);
        exp_q = '{{4'd0, 8'h5A}, {4'd15, 8'hA5}};
        check_drain("saturation", 1'b0);
    endtask

`ifdef TRACE_TRIGGER_EN
    task automatic test_trigger();
        bus.trig_mask  = 8'h80;
        bus.trig_value = 8'h80;
        do_arm(1'b0);
        n_tests++;
        if (bus.state !== 2'd1) begin
            n_fail++; $display("FAIL trig_armed: got state=%0d expected 1", bus.state);
        end
        sample(8'h01, 1'b0);
        sample(8'h02, 1'b0);
        n_tests++;
        if (bus.state !== 2'd1 || bus.count !== '0) begin
            n_fail++; $display("FAIL trig_wait: got state=%0d count=%0d expected 1/0", bus.state, bus.count);
        end
        sample(8'h80, 1'b0);
        n_tests++;
        if (bus.state !== 2'd2) begin
            n_fail++; $display("FAIL trig_fire: got state=%0d expected 2", bus.state);
        end
        sample(8'h81, 1'b1);
        bus.trig_mask  = '0;
        bus.trig_value = '0;
        exp_q = '{{4'd0, 8'h80}, {4'd1, 8'h81}};
        check_drain("trigger", 1'b0);
    endtask
`endif

    task automatic test_priority();
        do_arm(1'b1);
        sample(8'h01, 1'b0);
        sample(8'h02, 1'b1);
        n_tests++;
        if (bus.state !== 2'd3 || bus.count !== 3'd2) begin
            n_fail++; $display("FAIL prio_setup: got state=%0d count=%0d expected 3/2", bus.state, bus.count);
        end
        bus.arm  = 1'b1;
        bus.stop = 1'b1;
        bus.mode = 1'b0;
        step();
        bus.arm  = 1'b0;
        bus.stop = 1'b0;
        n_tests++;
        if (bus.state !== 2'd2 || bus.count !== '0) begin
            n_fail++; $display("FAIL prio_arm_wins: got state=%0d count=%0d expected 2/0", bus.state, bus.count);
        end
        bus.rd_en = 1'b1;
        sample(8'h10, 1'b0);
        sample(8'h10, 1'b0);
        n_tests++;
        if (bus.count !== 3'd1 || bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL prio_rd_in_capture: got count=%0d valid=%b expected 1/0", bus.count, bus.rd_valid);
        end
        bus.rd_en = 1'b0;
        sample(8'h20, 1'b1);
        exp_q = '{{4'd0, 8'h10}, {4'd2, 8'h20}};
        check_drain("priority", 1'b0);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        n_tests++;
        if (bus.count !== '0 || bus.state !== 2'd3) begin
            n_fail++; $display("FAIL prio_empty_pop: got count=%0d state=%0d expected 0/3", bus.count, bus.state);
        end
    endtask

    // Reference: list of written samples by edge number, then DEPTH-entry queue policy.
    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic            m;
            int              len;
            int              last_edge;
            logic [CH-1:0]   p;
            logic [CH-1:0]   prevp;
            logic            stopped;
            logic            ovf;
            int              d;
            m         = 1'($urandom_range(0, 1));
            len       = int'($urandom_range(3, 45));
            last_edge = 0;
            prevp     = '0;
            stopped   = 1'b0;
            ovf       = 1'b0;
            exp_q.delete();
            do_arm(m);
            for (int e = 1; e <= len; e++) begin
                p = (e == 1 || $urandom_range(0, 5) == 0) ? 8'($urandom) : prevp;
                if (!stopped) begin
                    if (e == 1 || p != prevp) begin
                        d = (e == 1) ? 0 : ((e - last_edge > TSMAX) ? TSMAX : e - last_edge);
                        exp_q.push_back({4'(d), p});
                        last_edge = e;
                        if (exp_q.size() > DP) begin
                            void'(exp_q.pop_front());
                            ovf = 1'b1;
                        end
                        if (m && exp_q.size() == DP) stopped = 1'b1;
                    end
                    prevp = p;
                end
                sample(p, e == len);
            end
            check_drain($sformatf("random%0d", it), ovf);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_stop_on_full();
        test_wrap();
        test_saturation();
`ifdef TRACE_TRIGGER_EN
        test_trigger();
`endif
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/signal_trace_buffer.md
# signal_trace_buffer

On-chip change-driven logic capture for the Atari 2600 core. It replaces VCD-only visibility of internal strobes such as TIA `stall_cpu` / `valid_read_cmd` with a synthesizable recorder. It samples `CHANNELS` probe bits every `clk`, stores an entry only when the probe vector changes, and tags each entry with a saturating cycle delta. It sits beside `tt_um_rejunity_atari2600` internals and is read back through spare IO or by the cocotb bench after capture stops.

## Interface
- `CHANNELS`, 8: probe width, 1..16.
- `DEPTH`, 16: entries stored; power of two, 2..64.
- `TS_WIDTH`, 8: delta-timestamp field width, 2..16.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `probe` in CHANNELS: signals under observation, synchronous to `clk`.
- `arm` in 1: one-cycle pulse; clear buffer and start capture.
- `stop` in 1: one-cycle pulse; end capture.
- `mode` in 1: 0 = wrap (overwrite oldest), 1 = stop when full; sampled on `arm`.
- `trig_mask`, `trig_value` in CHANNELS each: trigger pattern (present only with `TRACE_TRIGGER_EN`).
- `rd_en` in 1: pop oldest entry.
- `rd_data` out TS_WIDTH+CHANNELS: `{delta, probe}` of oldest entry, first-word-fall-through.
- `rd_valid` out 1: `rd_data` holds a valid entry.
- `count` out clog2(DEPTH)+1: entries held.
- `state` out 2: 0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 STOPPED.
- `overflow` out 1: at least one entry was overwritten in wrap mode.

## Operation
- Reset values: `state`=IDLE, `count`=0, `rd_valid`=0, `rd_data`=0, `overflow`=0. Pointers, delta counter and previous-probe register are cleared.
- `arm` in any state:
  - clears `count`, pointers and `overflow`, and latches `mode`;
  - goes to WAIT_TRIG (macro on) or CAPTURE (macro off).
  - `arm` and `stop` in the same cycle: `arm` wins.
- WAIT_TRIG: on the first edge where `(probe & trig_mask) == (trig_value & trig_mask)`, write that sample as the first entry, then go to CAPTURE. `stop` goes to STOPPED with no entries.
- CAPTURE, first sample edge after entry: always written (reference entry, delta 0). No-trigger path only.
- CAPTURE, later edges: write only when `probe != prev_probe`. `prev_probe` updates every edge in WAIT_TRIG and CAPTURE.
- Delta field: number of sample edges since the previous written entry, saturating at 2^TS_WIDTH−1. Saturated means at least that many edges.
- Full in mode 0: the write overwrites the oldest entry, the read pointer advances, `count` stays DEPTH, `overflow`←1.
- Full in mode 1: the write that makes `count`=DEPTH moves to STOPPED on the same edge.
- `stop` in CAPTURE moves to STOPPED. A change sampled on that edge is still written.
- STOPPED:
  - `rd_valid` = (`count`≠0); `rd_data` = oldest entry combinationally, 0 when `rd_valid`=0.
  - `rd_en`&&`rd_valid` pops: `count` decrements on that edge and the next entry is presented.
  - `rd_en` in any other state, or with `count`=0, is ignored.
- Pointer arithmetic is modulo DEPTH; `count` never exceeds DEPTH.

## Timing
- Probe-to-storage latency: 1 edge. The entry is visible in `count` the cycle after its sample edge.
- `arm` at edge N: the state change is visible after N. The first CAPTURE sample is edge N+1.
- Pop: `rd_data` advances the cycle after the `rd_en` edge. Popping every cycle is legal; back-to-back reads drain DEPTH entries in DEPTH cycles.
- Full→STOPPED (mode 1) and `overflow` set (mode 0) occur on the same edge as the causing write.
- `rst_n` low mid-capture or mid-readout returns all outputs to reset values immediately (asynchronous); buffer contents are lost.

## Configuration
- `TRACE_TRIGGER_EN` defined: `trig_mask`/`trig_value` ports exist, WAIT_TRIG is reachable, and `arm` enters WAIT_TRIG. `trig_mask`=0 triggers on the first edge.
- Undefined: the ports are absent, state 1 is never produced, and `arm` goes straight to CAPTURE.

## Test plan
- Reset: capture 3 entries, assert `rst_n`=0 mid-stream → `state`=0, `count`=0, `rd_valid`=0, `rd_data`=0, `overflow`=0 without a clock edge.
- Stop-on-full, CHANNELS=8, DEPTH=4, mode=1:
  - stimulus: arm; `probe`=0x00, changing to 0x01 at sample edge 4, 0x03 at 6, 0x07 at 7;
  - response: `state`=3 after edge 7; reads give {0,0x00}, {3,0x01}, {2,0x03}, {1,0x07}, then `rd_valid`=0.
- Wrap, DEPTH=4, mode=0: 6 changes 0x01..0x06 one per 2 edges, then stop → `overflow`=1, `count`=4, reads yield 0x03, 0x04, 0x05, 0x06 with delta 2 each.
- Saturation, TS_WIDTH=4: probe constant 40 edges then toggles → that entry's delta=15.
- Trigger (macro on): `trig_mask`=0x80, `trig_value`=0x80; probe walks 0x01, 0x02, 0x80, 0x81 → `state`=1 until 0x80; first entry {0,0x80}, second {1,0x81}.
- Priority: `arm`+`stop` same cycle from STOPPED with data → `state`=CAPTURE, `count`=0; `rd_en` during CAPTURE leaves `count` unchanged.
